tis_fetch_decode: RTL and testbench

- Per-node instruction sequencer: holds a DEPTH-word program store, owns the program counter, and presents the registered current instruction as decoded control fields to the node datapath.
- Sits between the program loader and the node ALU, register file and port muxes.
- Generalises the combinational op decoder:
  - parametrised data width and program depth;
  - run/stall handshake;
  - conditional and relative jump resolution with pc clamping;
  - wrap-around at program end.

---
 rtl/tis_fetch_decode.sv | 165 ++++++++++++++++
 tb/tb_tis_fetch_decode.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_fetch_decode.sv
// rtl/tis_fetch_decode.sv - per-node program store, program counter and instruction field decode
module tis_fetch_decode #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 15,
    parameter int ADDR_WIDTH = 4,
    parameter int OP_WIDTH   = DATA_WIDTH + 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [OP_WIDTH-1:0]   prog_data,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  run,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] acc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_valid,
    output logic                  retire,
    output logic [DATA_WIDTH-1:0] const_value,
    output logic [3:0]            pc_instr,
    output logic [1:0]            alu_instr,
    output logic [1:0]            registers_instr,
    output logic [1:0]            in_mux_sel,
    output logic                  out_mux_sel
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int SW = DATA_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [OP_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [OP_WIDTH-1:0]   ir;

    // Raw fields of the instruction register, used for sequencing regardless of masking
    logic [3:0]            ir_op;
    logic [DATA_WIDTH-1:0] ir_const;
    logic [ADDR_WIDTH-1:0] tgt;

    assign ir_op    = ir[OP_WIDTH-1 -: 4];
    assign ir_const = ir[DATA_WIDTH-1:0];
    assign tgt      = ir_const[ADDR_WIDTH-1:0];

    // Effective program length saturates at the store depth
    logic [LW-1:0] eff_len;
    logic [LW-1:0] last_idx;
    logic [LW-1:0] pc_ext;

    assign eff_len  = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    assign last_idx = eff_len - LW'(1);
    assign pc_ext   = {1'b0, pc};

    // Accumulator condition flags (acc is two's complement)
    logic acc_zero;
    logic acc_neg;
    logic acc_pos;

    assign acc_zero = (acc == '0);
    assign acc_neg  = acc[DATA_WIDTH-1];
    assign acc_pos  = ~acc_zero & ~acc_neg;

    // Sequential successor with wrap at the last program word
    logic [ADDR_WIDTH-1:0] seq_npc;
    assign seq_npc = (pc_ext >= last_idx) ? '0 : pc + ADDR_WIDTH'(1);

    // Absolute jump target clamped into the program
    logic [ADDR_WIDTH-1:0] abs_npc;
    assign abs_npc = ({1'b0, tgt} >= eff_len) ? last_idx[ADDR_WIDTH-1:0] : tgt;

    // Relative jump: signed sum one bit wider than the data, clamped to [0, L-1]
    logic signed [SW-1:0]  jro_sum;
    logic signed [SW-1:0]  jro_max;
    logic [ADDR_WIDTH-1:0] jro_npc;

    assign jro_sum = $signed({{(SW-ADDR_WIDTH){1'b0}}, pc})
                   + $signed({ir_const[DATA_WIDTH-1], ir_const});
    assign jro_max = $signed({{(SW-LW){1'b0}}, last_idx});

    // Clamp the relative target into the program range
    always_comb begin
        jro_npc = jro_sum[ADDR_WIDTH-1:0];
        if (jro_sum[SW-1]) begin
            jro_npc = '0;
        end else if (jro_sum > jro_max) begin
            jro_npc = last_idx[ADDR_WIDTH-1:0];
        end
    end

    // Select the next pc from the sequencing opcode
    logic [ADDR_WIDTH-1:0] npc;
    always_comb begin
        npc = seq_npc;
        case (ir_op)
            4'd1: npc = abs_npc;
            4'd2: if (acc_zero)  npc = abs_npc;
            4'd3: if (!acc_zero) npc = abs_npc;
            4'd4: if (acc_pos)   npc = abs_npc;
            4'd5: if (acc_neg)   npc = abs_npc;
            4'd6: npc = jro_npc;
            default: npc = seq_npc;
        endcase
        // A shortened program that leaves pc outside it restarts from the top
        if (pc_ext >= eff_len) begin
            npc = '0;
        end
    end

    // Program store: loaded only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if (state == IDLE && prog_we && ({1'b0, prog_addr} < LW'(DEPTH))) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM: owns pc, instruction register and the valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && (eff_len != '0)) begin
                        state       <= RUN;
                        pc          <= '0;
                        ir          <= mem[0];
                        instr_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state       <= IDLE;
                        pc          <= '0;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        pc <= npc;
                        ir <= mem[npc];
                    end
                end
                default: begin
                    state       <= IDLE;
                    pc          <= '0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Decoded fields, forced to zero while no instruction is presented
    assign retire          = instr_valid & run & ~stall;
    assign pc_instr        = instr_valid ? ir[OP_WIDTH-1 -: 4]  : '0;
    assign alu_instr       = instr_valid ? ir[OP_WIDTH-5 -: 2]  : '0;
    assign registers_instr = instr_valid ? ir[OP_WIDTH-7 -: 2]  : '0;
    assign in_mux_sel      = instr_valid ? ir[OP_WIDTH-9 -: 2]  : '0;
    assign out_mux_sel     = instr_valid ? ir[OP_WIDTH-11]      : 1'b0;
    assign const_value     = instr_valid ? ir[DATA_WIDTH-1:0]   : '0;

endmodule

// File: tb/tb_tis_fetch_decode.sv
// tb/tb_tis_fetch_decode.sv - directed self-checking bench for tis_fetch_decode
module tb_tis_fetch_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [21:0] prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic [10:0] acc = '0;
    logic [3:0]  pc;
    logic        instr_valid;
    logic        retire;
    logic [10:0] const_value;
    logic [3:0]  pc_instr;
    logic [1:0]  alu_instr;
    logic [1:0]  registers_instr;
    logic [1:0]  in_mux_sel;
    logic        out_mux_sel;

    int checks = 0;
    int errors = 0;

    tis_fetch_decode dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .run(run), .stall(stall),
        .acc(acc), .pc(pc), .instr_valid(instr_valid), .retire(retire),
        .const_value(const_value), .pc_instr(pc_instr), .alu_instr(alu_instr),
        .registers_instr(registers_instr), .in_mux_sel(in_mux_sel),
        .out_mux_sel(out_mux_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] mk(input logic [3:0] op, input logic [10:0] c);
        return {op, 2'd0, 2'd0, 2'd0, 1'b0, c};
    endfunction

    task automatic load(input logic [3:0] a, input logic [21:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic load_three_next();
        load(4'd0, {4'd0, 2'd2, 2'd1, 2'd3, 1'b1, 11'd5});
        load(4'd1, mk(4'd0, 11'h7FD));
        load(4'd2, mk(4'd0, 11'd7));
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0 || retire !== 1'b0) begin
            errors++; $display("FAIL reset_state: valid=%b pc=%0d retire=%b, required 0 0 0", instr_valid, pc, retire);
        end
        checks++;
        if (const_value !== 11'd0 || pc_instr !== 4'd0) begin
            errors++; $display("FAIL reset_fields: const=%h op=%h, required 0 0", const_value, pc_instr);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sequence();
        logic [3:0]  exp_pc [5] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        logic [10:0] exp_c  [5] = '{11'd5, 11'h7FD, 11'd7, 11'd5, 11'h7FD};
        load_three_next();
        prog_len = 5'd3;
        run = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL seq_latency: valid=%b before edge, required 0", instr_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc !== exp_pc[i] || const_value !== exp_c[i] || retire !== 1'b1) begin
                errors++; $display("FAIL seq_step%0d: valid=%b pc=%0d const=%h retire=%b, required 1 %0d %h 1",
                                   i, instr_valid, pc, const_value, retire, exp_pc[i], exp_c[i]);
            end
            if (i == 0) begin
                checks++;
                if (pc_instr !== 4'd0 || alu_instr !== 2'd2 || registers_instr !== 2'd1 ||
                    in_mux_sel !== 2'd3 || out_mux_sel !== 1'b1) begin
                    errors++; $display("FAIL seq_fields: op=%h alu=%h reg=%h in=%h out=%b, required 0 2 1 3 1",
                                       pc_instr, alu_instr, registers_instr, in_mux_sel, out_mux_sel);
                end
            end
        end
        run = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0 || const_value !== 11'd0 || out_mux_sel !== 1'b0) begin
            errors++; $display("FAIL seq_stop: valid=%b pc=%0d const=%h out=%b, required 0 0 0 0",
                               instr_valid, pc, const_value, out_mux_sel);
        end
    endtask

    task automatic test_cond_jump();
        logic [3:0] exp_a [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [3:0] exp_b [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
        logic [3:0] exp_c [3] = '{4'd0, 4'd1, 4'd0};
        load(4'd0, mk(4'd0, 11'd0));
        load(4'd1, mk(4'd2, 11'd0));
        load(4'd2, mk(4'd0, 11'd0));
        prog_len = 5'd3;
        acc = 11'd0; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); checks++;
            if (pc !== exp_a[i]) begin errors++; $display("FAIL jez_taken%0d: pc=%0d, required %0d", i, pc, exp_a[i]); end
        end
        run = 1'b0; tick();
        acc = 11'd5; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); checks++;
            if (pc !== exp_b[i]) begin errors++; $display("FAIL jez_not_taken%0d: pc=%0d, required %0d", i, pc, exp_b[i]); end
        end
        run = 1'b0; tick();
        load(4'd1, mk(4'd5, 11'd0));
        acc = 11'h7FF; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); checks++;
            if (pc !== exp_c[i]) begin errors++; $display("FAIL jlz_taken%0d: pc=%0d, required %0d", i, pc, exp_c[i]); end
        end
        run = 1'b0; tick();
        acc = 11'd0;
    endtask

    task automatic test_stall();
        load_three_next();
        prog_len = 5'd3;
        run = 1'b1;
        tick(); tick();
        stall = 1'b1;
        #1;
        checks++;
        if (retire !== 1'b0) begin errors++; $display("FAIL stall_retire_comb: retire=%b, required 0", retire); end
        for (int i = 0; i < 3; i++) begin
            tick(); checks++;
            if (pc !== 4'd1 || const_value !== 11'h7FD || retire !== 1'b0 || instr_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: pc=%0d const=%h retire=%b valid=%b, required 1 7fd 0 1",
                                   i, pc, const_value, retire, instr_valid);
            end
        end
        stall = 1'b0;
        tick(); checks++;
        if (pc !== 4'd2 || const_value !== 11'd7) begin
            errors++; $display("FAIL stall_release: pc=%0d const=%h, required 2 007", pc, const_value);
        end
        run = 1'b0; tick();
    endtask

    task automatic test_jro_clamp();
        logic [3:0] exp_a [6] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd0, 4'd1};
        logic [3:0] exp_b [5] = '{4'd0, 4'd1, 4'd3, 4'd3, 4'd3};
        load(4'd0, mk(4'd0, 11'd0));
        load(4'd1, mk(4'd6, 11'd7));
        load(4'd2, mk(4'd6, 11'h7FB));
        load(4'd3, mk(4'd1, 11'd2));
        prog_len = 5'd4;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); checks++;
            if (pc !== exp_a[i]) begin errors++; $display("FAIL jro%0d: pc=%0d, required %0d", i, pc, exp_a[i]); end
        end
        run = 1'b0; tick();
        load(4'd3, mk(4'd1, 11'd9));
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); checks++;
            if (pc !== exp_b[i]) begin errors++; $display("FAIL jmp_clamp%0d: pc=%0d, required %0d", i, pc, exp_b[i]); end
        end
        run = 1'b0; tick();
    endtask

    task automatic test_reset_mid_run();
        load_three_next();
        prog_len = 5'd3;
        run = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (pc !== 4'd2) begin errors++; $display("FAIL rst_mid_setup: pc=%0d, required 2", pc); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0 || const_value !== 11'd0) begin
            errors++; $display("FAIL rst_mid_async: valid=%b pc=%0d const=%h, required 0 0 0", instr_valid, pc, const_value);
        end
        tick();
        reset = 1'b0;
        tick(); checks++;
        if (instr_valid !== 1'b1 || pc !== 4'd0 || const_value !== 11'd5) begin
            errors++; $display("FAIL rst_mid_restart: valid=%b pc=%0d const=%h, required 1 0 005", instr_valid, pc, const_value);
        end
        run = 1'b0; tick();
    endtask

    task automatic test_we_in_run_and_zero_len();
        load_three_next();
        prog_len = 5'd3;
        run = 1'b1;
        tick();
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = mk(4'd1, 11'd100);
        tick();
        prog_we = 1'b0; run = 1'b0;
        tick();
        run = 1'b1;
        tick(); checks++;
        if (instr_valid !== 1'b1 || const_value !== 11'd5 || pc_instr !== 4'd0) begin
            errors++; $display("FAIL we_in_run: valid=%b const=%h op=%h, required 1 005 0", instr_valid, const_value, pc_instr);
        end
        run = 1'b0; tick();
        prog_len = 5'd0; run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); checks++;
            if (instr_valid !== 1'b0 || retire !== 1'b0) begin
                errors++; $display("FAIL zero_len%0d: valid=%b retire=%b, required 0 0", i, instr_valid, retire);
            end
        end
        run = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_cond_jump();
        test_stall();
        test_jro_clamp();
        test_reset_mid_run();
        test_we_in_run_and_zero_len();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
